// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter: round-robin sharing of one quick_rs232 transmitter among byte-stream requesters
module rs232_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_FRAME_LEN = 64,
  parameter int TIMEOUT_TICKS = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx_transaction,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_data_ready,
  input  logic                          tx_data_copied,
  input  logic                          tx_busy,
  output logic                          timeout_err
);
  localparam int ow = $clog2(NUM_REQ);
  localparam int cw = $clog2(MAX_FRAME_LEN + 1);
  localparam int tw = $clog2(TIMEOUT_TICKS);
  localparam logic [cw-1:0] cnt_max = cw'(MAX_FRAME_LEN);
  localparam logic [tw-1:0] tmr_max = tw'(TIMEOUT_TICKS - 1);
  localparam logic [NUM_REQ-1:0] one = NUM_REQ'(1);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_COPY, CLOSE} state_t;
  state_t state;
  logic [ow-1:0] owner, last_owner, pick, idx;
  logic [cw-1:0] byte_cnt;
  logic [tw-1:0] tmr;
  logic last_flag;
  logic [DATA_WIDTH-1:0] slices [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slices[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end
  // round-robin search from the requester after the previous owner; the nearest one wins
  always_comb begin
    pick = last_owner;
    idx = last_owner;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ow'((int'(last_owner) + i) % NUM_REQ);
      pick = req_valid[idx] ? idx : pick;
    end
  end
  // frame sequencing: grant, byte handshake with timeout, close after the serializer drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last_owner <= ow'(NUM_REQ - 1);
      byte_cnt <= '0;
      tmr <= '0;
      last_flag <= 1'b0;
      req_ack <= '0;
      grant <= '0;
      tx_transaction <= 1'b0;
      tx_data <= '0;
      tx_data_ready <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_ack <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          owner <= pick;
          grant <= one << pick;
          tx_transaction <= 1'b1;
          byte_cnt <= '0;
          state <= LOAD;
        end
        LOAD: if (req_valid[owner]) begin
          tx_data <= slices[owner];
          tx_data_ready <= 1'b1;
          req_ack <= one << owner;
          last_flag <= req_last[owner];
          byte_cnt <= byte_cnt + 1'b1;
          tmr <= '0;
          state <= WAIT_COPY;
        end
        WAIT_COPY: if (tx_data_copied) begin
          tx_data_ready <= 1'b0;
          state <= (last_flag || byte_cnt == cnt_max) ? CLOSE : LOAD;
        end else if (tmr == tmr_max) begin
          tx_data_ready <= 1'b0;
          timeout_err <= 1'b1;
          state <= CLOSE;
        end else begin
          tmr <= tmr + 1'b1;
        end
        CLOSE: if (!tx_busy) begin
          tx_transaction <= 1'b0;
          grant <= '0;
          last_owner <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
